fpu_wb_sched: RTL and testbench
===============================

Name: fpu_wb_sched

Overview:
- Issue/writeback scheduler for the fixed-latency pipelined FPU units: fadd, fsub, fdiv, fsqrt, fcvtws, fcvtsw and fmul.
- Accepts at most one FP op per cycle and reserves the single FP-register writeback slot that the op's result will occupy.
- Stalls issue on writeback-slot collision or same-destination (WAW) hazard.
- At the right cycle, selects the result word from the packed 224-bit FPU result bus and presents it as one writeback.
- Sits between decode/issue and the FP register file.

Parameters:
- LAT_FADD, 2, cycles from issue cycle to fadd result valid on bus
- LAT_FSUB, 2, fsub latency
- LAT_FDIV, 5, fdiv latency
- LAT_FSQRT, 4, fsqrt latency
- LAT_FCVTWS, 3, fcvt.w.s latency
- LAT_FCVTSW, 3, fcvt.s.w latency
- LAT_FMUL, 2, fmul latency
- MAX_LAT, 8, reservation depth; every LAT_* must be in 1..MAX_LAT (elaboration error otherwise)

Ports:
- clk  in  1  clock
- rstn  in  1  asynchronous active-low reset
- issue_valid  in  1  op offered this cycle
- issue_unit  in  3  unit id: 0 fadd, 1 fsub, 2 fdiv, 3 fsqrt, 4 fcvtws, 5 fcvtsw, 6 fmul, 7 reserved
- issue_rd  in  5  destination FP register
- issue_ready  out  1  op accepted when issue_valid && issue_ready
- flush  in  1  discard all in-flight reservations
- fpu_results  in  224  packed unit results: [31:0] fadd, [63:32] fsub, [95:64] fdiv, [127:96] fsqrt, [159:128] fcvtws, [191:160] fcvtsw, [223:192] fmul
- wb_valid  out  1  writeback this cycle
- wb_rd  out  5  writeback destination
- wb_data  out  32  writeback data
- pending  out  32  bit r set while any reservation targets register r
- inflight  out  4  count of valid reservations

Behaviour:
- Reservation line: slot[0..MAX_LAT-1], each holding {valid, unit[2:0], rd[4:0]}.
- Every cycle, slot[i] <= slot[i+1] and slot[MAX_LAT-1] <= empty.
- Acceptance: on accept with latency L, slot[L-1] <= {1, unit, rd}, overriding the shifted-in value (which is guaranteed empty, see below).
- Issue timing: an op accepted in cycle t yields wb_valid=1 in cycle t+L; L=1 means the next cycle.
- Writeback (combinational from slot[0]):
  - wb_valid = slot[0].valid
  - wb_rd = slot[0].rd
  - wb_data = 32-bit slice of fpu_results selected by slot[0].unit
  - wb_data and wb_rd are 0 when wb_valid=0.
- issue_ready = !flush && !collide && !waw.
  - collide = (L < MAX_LAT) && slot[L].valid, i.e. the slot that would shift into L-1 is taken.
  - waw = pending[issue_rd].
  - issue_ready does not depend on issue_valid; it is computed for the presented unit/rd.
- Unit 7: issue_ready follows the flush term only. It is accepted and dropped, with no reservation and no writeback.
- pending is the OR over valid slots of the one-hot rd, combinational from the slots.
  - A register whose result is in slot[0] this cycle is still pending. A same-rd op therefore cannot issue in the writeback cycle; it can issue the cycle after.
- inflight is the popcount of valid slots.
- flush: all slots are cleared at the next edge. During the flush cycle, issue_ready=0 and the slot[0] writeback still occurs (already produced).
- Reset (rstn low, asynchronous): all slots invalid.
  - wb_valid=0, wb_rd=0, wb_data=0, pending=0, inflight=0.
  - issue_ready reflects the empty state (1 unless flush).
  - Reset mid-operation drops all in-flight results silently.
- Throughput: back-to-back issues of equal latency, one per cycle, never collide. Collisions arise only when a shorter-latency op would land in a slot already reserved by an older longer-latency op.

Decomposition:
- Package fpu_sched_pkg:
  - typedef fpu_unit_t (enum of the seven unit ids plus reserved)
  - typedef resv_t struct {valid, unit, rd}
  - function unit_lat(fpu_unit_t) returning the parameterised latency
  - localparam slice offsets for fpu_results
- One sub-module, fpu_result_mux: combinational unit-id to 32-bit slice select.
- Slots, shift logic, hazard checks and the pending/inflight reduction stay in fpu_wb_sched.

Test Plan:
- Idle: fadd rd=3 issued at cycle 10 with fpu_results[31:0]=0x3F800000 at cycle 12 -> wb_valid only in cycle 12, wb_rd=3, wb_data=0x3F800000; pending[3]=1 in cycles 11-12, 0 in cycle 13.
- Collision: fdiv rd=1 at cycle 0 (lands cycle 5), then fsqrt rd=2 offered at cycle 1 (would land cycle 5) -> issue_ready=0 at cycle 1. Re-offered at cycle 2 -> accepted, writes back at cycle 6.
- WAW: fdiv rd=4 at cycle 0, fmul rd=4 offered cycles 1-5 -> issue_ready=0 through cycle 5, accepted at cycle 6, wb at cycle 8. Only two writebacks to rd=4, in order fdiv then fmul.
- Streaming: 8 consecutive fmul rd=8..15 in cycles 0-7 -> issue_ready always 1, writebacks rd=8..15 in cycles 2-9, inflight peaks at 2.
- Flush: fdiv rd=5 at cycle 0, flush in cycle 2 -> issue_ready=0 in cycle 2, no wb in cycle 5, pending=0 and inflight=0 from cycle 3.
- Async reset: rstn low mid-cycle with 3 ops in flight -> wb_valid, pending and inflight drop to 0 immediately without a clock edge. No writebacks after release.

Source files
------------

// File: rtl/fpu_sched_pkg.sv
// rtl/fpu_sched_pkg.sv - shared types, slice offsets and latency lookup for the FP writeback scheduler
package fpu_sched_pkg;

    typedef enum logic [2:0] {
        U_FADD   = 3'd0,
        U_FSUB   = 3'd1,
        U_FDIV   = 3'd2,
        U_FSQRT  = 3'd3,
        U_FCVTWS = 3'd4,
        U_FCVTSW = 3'd5,
        U_FMUL   = 3'd6,
        U_RSVD   = 3'd7
    } fpu_unit_t;

    typedef struct packed {
        logic      valid;
        fpu_unit_t unit;
        logic [4:0] rd;
    } resv_t;

    // Per-unit latency table, indexed by unit id (entry 7 unused).
    typedef logic [7:0][3:0] lat_tbl_t;

    localparam int RES_W      = 224;
    localparam int OFF_FADD   = 0;
    localparam int OFF_FSUB   = 32;
    localparam int OFF_FDIV   = 64;
    localparam int OFF_FSQRT  = 96;
    localparam int OFF_FCVTWS = 128;
    localparam int OFF_FCVTSW = 160;
    localparam int OFF_FMUL   = 192;

    function automatic logic [3:0] unit_lat(input fpu_unit_t u, input lat_tbl_t tbl);
        return tbl[u];
    endfunction

endpackage

// File: rtl/fpu_result_mux.sv
// rtl/fpu_result_mux.sv - selects one unit's 32-bit result from the packed FPU result bus
// Ports: results (packed 224-bit unit results), unit (unit id), data (selected word, 0 for reserved id)
module fpu_result_mux
    import fpu_sched_pkg::*;
(
    input  logic [RES_W-1:0] results,
    input  fpu_unit_t        unit,
    output logic [31:0]      data
);

    always_comb begin
        data = '0;
        case (unit)
            U_FADD:   data = results[OFF_FADD   +: 32];
            U_FSUB:   data = results[OFF_FSUB   +: 32];
            U_FDIV:   data = results[OFF_FDIV   +: 32];
            U_FSQRT:  data = results[OFF_FSQRT  +: 32];
            U_FCVTWS: data = results[OFF_FCVTWS +: 32];
            U_FCVTSW: data = results[OFF_FCVTSW +: 32];
            U_FMUL:   data = results[OFF_FMUL   +: 32];
            default:  data = '0;
        endcase
    end

endmodule

// File: rtl/fpu_wb_sched.sv
// rtl/fpu_wb_sched.sv - FP issue/writeback scheduler reserving the single FP register writeback slot
// Ports: clk, rstn (async active-low); issue_valid/issue_unit/issue_rd in, issue_ready out;
//        flush; fpu_results (packed unit results); wb_valid/wb_rd/wb_data writeback;
//        pending (per-register outstanding mask); inflight (reservation count)
module fpu_wb_sched
    import fpu_sched_pkg::*;
#(
    parameter int LAT_FADD   = 2,
    parameter int LAT_FSUB   = 2,
    parameter int LAT_FDIV   = 5,
    parameter int LAT_FSQRT  = 4,
    parameter int LAT_FCVTWS = 3,
    parameter int LAT_FCVTSW = 3,
    parameter int LAT_FMUL   = 2,
    parameter int MAX_LAT    = 8
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic              issue_valid,
    input  logic [2:0]        issue_unit,
    input  logic [4:0]        issue_rd,
    output logic              issue_ready,
    input  logic              flush,
    input  logic [RES_W-1:0]  fpu_results,
    output logic              wb_valid,
    output logic [4:0]        wb_rd,
    output logic [31:0]       wb_data,
    output logic [31:0]       pending,
    output logic [3:0]        inflight
);

    if (MAX_LAT < 1 || MAX_LAT > 15 ||
        LAT_FADD   < 1 || LAT_FADD   > MAX_LAT ||
        LAT_FSUB   < 1 || LAT_FSUB   > MAX_LAT ||
        LAT_FDIV   < 1 || LAT_FDIV   > MAX_LAT ||
        LAT_FSQRT  < 1 || LAT_FSQRT  > MAX_LAT ||
        LAT_FCVTWS < 1 || LAT_FCVTWS > MAX_LAT ||
        LAT_FCVTSW < 1 || LAT_FCVTSW > MAX_LAT ||
        LAT_FMUL   < 1 || LAT_FMUL   > MAX_LAT) begin : g_bad_lat
        $error("fpu_wb_sched: every LAT_* must be in 1..MAX_LAT and MAX_LAT in 1..15");
    end

    localparam lat_tbl_t LAT_TBL = {4'd0, 4'(LAT_FMUL), 4'(LAT_FCVTSW), 4'(LAT_FCVTWS),
                                    4'(LAT_FSQRT), 4'(LAT_FDIV), 4'(LAT_FSUB), 4'(LAT_FADD)};

    resv_t      slots_q [MAX_LAT];
    resv_t      slots_d [MAX_LAT];
    fpu_unit_t  unit;
    logic [3:0] lat;
    logic       is_rsvd;
    logic       collide;
    logic       waw;
    logic       accept;
    logic [31:0] mux_data;

    assign unit    = fpu_unit_t'(issue_unit);
    assign lat     = unit_lat(unit, LAT_TBL);
    assign is_rsvd = (unit == U_RSVD);

    // The entry now in slot[lat] shifts into slot[lat-1] at the edge, which is
    // exactly where this op would land; lat == MAX_LAT matches no slot.
    always_comb begin
        collide = 1'b0;
        for (int i = 0; i < MAX_LAT; i++) begin
            if (lat == 4'(i)) collide = slots_q[i].valid;
        end
    end

    always_comb begin
        pending  = '0;
        inflight = '0;
        for (int i = 0; i < MAX_LAT; i++) begin
            if (slots_q[i].valid) begin
                pending[slots_q[i].rd] = 1'b1;
                inflight = inflight + 4'd1;
            end
        end
    end

    assign waw = pending[issue_rd];

    // Reserved id needs no slot, so only flush holds it back; it is then dropped.
    assign issue_ready = !flush && (is_rsvd || (!collide && !waw));
    assign accept      = issue_valid && issue_ready && !is_rsvd;

    always_comb begin
        for (int i = 0; i < MAX_LAT - 1; i++) begin
            slots_d[i] = slots_q[i + 1];
        end
        slots_d[MAX_LAT - 1] = '0;
        if (accept) begin
            for (int i = 0; i < MAX_LAT; i++) begin
                if (lat == 4'(i + 1)) slots_d[i] = '{valid: 1'b1, unit: unit, rd: issue_rd};
            end
        end
        if (flush) begin
            for (int i = 0; i < MAX_LAT; i++) begin
                slots_d[i] = '0;
            end
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            for (int i = 0; i < MAX_LAT; i++) slots_q[i] <= '0;
        end else begin
            for (int i = 0; i < MAX_LAT; i++) slots_q[i] <= slots_d[i];
        end
    end

    fpu_result_mux u_result_mux (
        .results (fpu_results),
        .unit    (slots_q[0].unit),
        .data    (mux_data)
    );

    assign wb_valid = slots_q[0].valid;
    assign wb_rd    = slots_q[0].valid ? slots_q[0].rd : 5'd0;
    assign wb_data  = slots_q[0].valid ? mux_data : 32'd0;

endmodule

// File: tb/tb_fpu_wb_sched.sv
// tb/tb_fpu_wb_sched.sv - self-checking bench for fpu_wb_sched with directed scenarios and a random model run
module tb_fpu_wb_sched;

    logic         clk = 1'b0;
    logic         rstn = 1'b0;
    logic         issue_valid = 1'b0;
    logic [2:0]   issue_unit = '0;
    logic [4:0]   issue_rd = '0;
    logic         issue_ready;
    logic         flush = 1'b0;
    logic [223:0] fpu_results = '0;
    logic         wb_valid;
    logic [4:0]   wb_rd;
    logic [31:0]  wb_data;
    logic [31:0]  pending;
    logic [3:0]   inflight;

    always #5 clk = ~clk;

    fpu_wb_sched dut (
        .clk         (clk),
        .rstn        (rstn),
        .issue_valid (issue_valid),
        .issue_unit  (issue_unit),
        .issue_rd    (issue_rd),
        .issue_ready (issue_ready),
        .flush       (flush),
        .fpu_results (fpu_results),
        .wb_valid    (wb_valid),
        .wb_rd       (wb_rd),
        .wb_data     (wb_data),
        .pending     (pending),
        .inflight    (inflight)
    );

    // Reference model: a list of booked writebacks, each with the absolute cycle it is due.
    typedef struct {
        int due;
        int unit;
        int rd;
    } wb_ev_t;

    wb_ev_t evq[$];
    int     lat[8] = '{2, 2, 5, 4, 3, 3, 2, 0};
    int     cyc = 0;
    int     n_vec = 0;
    int     n_bad = 0;
    bit     p_v = 0, p_fl = 0;
    int     p_u = 0, p_rd = 0;
    bit          e_ready, e_valid;
    logic [4:0]  e_rd;
    logic [31:0] e_data, e_pend;
    int          e_infl;

    function automatic bit model_ready(input int u, input int rd, input bit fl);
        if (fl) return 1'b0;
        if (u == 7) return 1'b1;
        foreach (evq[k]) begin
            if (evq[k].due == cyc + lat[u]) return 1'b0;
            if (evq[k].rd == rd) return 1'b0;
        end
        return 1'b1;
    endfunction

    task automatic keep_due_range(input int lo, input int hi);
        wb_ev_t keep[$];
        keep = {};
        foreach (evq[k]) if (evq[k].due >= lo && evq[k].due <= hi) keep.push_back(evq[k]);
        evq = keep;
    endtask

    // Advance one cycle: commit last cycle's op to the model, drive new inputs,
    // then settle to the falling edge and compute the model's expectations.
    task automatic step(input bit v, input int u, input int rd, input bit fl);
        @(posedge clk);
        if (p_v && e_ready && p_u != 7) evq.push_back('{cyc + lat[p_u], p_u, p_rd});
        if (p_fl) keep_due_range(0, cyc);
        cyc++;
        keep_due_range(cyc, 1 << 30);
        #1;
        issue_valid = v;
        issue_unit  = 3'(u);
        issue_rd    = 5'(rd);
        flush       = fl;
        for (int k = 0; k < 7; k++) fpu_results[32*k +: 32] = $urandom;
        p_v = v; p_u = u; p_rd = rd; p_fl = fl;
        @(negedge clk);
        e_ready = model_ready(u, rd, fl);
        e_valid = 1'b0; e_rd = '0; e_data = '0; e_pend = '0;
        e_infl  = evq.size();
        foreach (evq[k]) begin
            e_pend[evq[k].rd] = 1'b1;
            if (evq[k].due == cyc) begin
                e_valid = 1'b1;
                e_rd    = 5'(evq[k].rd);
                e_data  = fpu_results[32*evq[k].unit +: 32];
            end
        end
    endtask

    task automatic drain();
        repeat (10) step(0, 0, 0, 0);
    endtask

    task automatic test_reset();
        #12;
        n_vec++; if (wb_valid !== 1'b0) begin n_bad++; $display("FAIL reset_wb_valid got %0b want 0", wb_valid); end
        n_vec++; if (wb_rd !== 5'd0) begin n_bad++; $display("FAIL reset_wb_rd got %0d want 0", wb_rd); end
        n_vec++; if (wb_data !== 32'd0) begin n_bad++; $display("FAIL reset_wb_data got %h want 0", wb_data); end
        n_vec++; if (pending !== 32'd0) begin n_bad++; $display("FAIL reset_pending got %h want 0", pending); end
        n_vec++; if (inflight !== 4'd0) begin n_bad++; $display("FAIL reset_inflight got %0d want 0", inflight); end
        n_vec++; if (issue_ready !== 1'b1) begin n_bad++; $display("FAIL reset_ready got %0b want 1", issue_ready); end
        rstn = 1'b1;
    endtask

    task automatic test_idle();
        step(1, 0, 3, 0);
        n_vec++; if (issue_ready !== 1'b1) begin n_bad++; $display("FAIL idle_ready got %0b want 1", issue_ready); end
        n_vec++; if (pending[3] !== 1'b0) begin n_bad++; $display("FAIL idle_pend_t0 got %0b want 0", pending[3]); end
        step(0, 0, 0, 0);
        n_vec++; if (wb_valid !== 1'b0) begin n_bad++; $display("FAIL idle_wb_early got %0b want 0", wb_valid); end
        n_vec++; if (pending[3] !== 1'b1) begin n_bad++; $display("FAIL idle_pend_t1 got %0b want 1", pending[3]); end
        step(0, 0, 0, 0);
        fpu_results[31:0] = 32'h3F80_0000;
        #1;
        n_vec++; if (wb_valid !== 1'b1) begin n_bad++; $display("FAIL idle_wb_valid got %0b want 1", wb_valid); end
        n_vec++; if (wb_rd !== 5'd3) begin n_bad++; $display("FAIL idle_wb_rd got %0d want 3", wb_rd); end
        n_vec++; if (wb_data !== 32'h3F80_0000) begin n_bad++; $display("FAIL idle_wb_data got %h want 3f800000", wb_data); end
        n_vec++; if (pending[3] !== 1'b1) begin n_bad++; $display("FAIL idle_pend_t2 got %0b want 1", pending[3]); end
        step(0, 0, 0, 0);
        n_vec++; if (wb_valid !== 1'b0) begin n_bad++; $display("FAIL idle_wb_late got %0b want 0", wb_valid); end
        n_vec++; if (pending[3] !== 1'b0) begin n_bad++; $display("FAIL idle_pend_t3 got %0b want 0", pending[3]); end
        drain();
    endtask

    task automatic test_collision();
        step(1, 2, 1, 0);
        n_vec++; if (issue_ready !== 1'b1) begin n_bad++; $display("FAIL coll_fdiv_ready got %0b want 1", issue_ready); end
        step(1, 3, 2, 0);
        n_vec++; if (issue_ready !== 1'b0) begin n_bad++; $display("FAIL coll_stall got %0b want 0", issue_ready); end
        step(1, 3, 2, 0);
        n_vec++; if (issue_ready !== 1'b1) begin n_bad++; $display("FAIL coll_retry got %0b want 1", issue_ready); end
        step(0, 0, 0, 0);
        step(0, 0, 0, 0);
        step(0, 0, 0, 0);
        n_vec++; if (wb_valid !== 1'b1 || wb_rd !== 5'd1) begin n_bad++; $display("FAIL coll_wb5 got v=%0b rd=%0d want v=1 rd=1", wb_valid, wb_rd); end
        n_vec++; if (wb_data !== fpu_results[95:64]) begin n_bad++; $display("FAIL coll_wb5_data got %h want %h", wb_data, fpu_results[95:64]); end
        step(0, 0, 0, 0);
        n_vec++; if (wb_valid !== 1'b1 || wb_rd !== 5'd2) begin n_bad++; $display("FAIL coll_wb6 got v=%0b rd=%0d want v=1 rd=2", wb_valid, wb_rd); end
        n_vec++; if (wb_data !== fpu_results[127:96]) begin n_bad++; $display("FAIL coll_wb6_data got %h want %h", wb_data, fpu_results[127:96]); end
        drain();
    endtask

    task automatic test_waw();
        int n_wb4 = 0;
        step(1, 2, 4, 0);
        for (int c = 1; c <= 5; c++) begin
            step(1, 6, 4, 0);
            n_vec++; if (issue_ready !== 1'b0) begin n_bad++; $display("FAIL waw_stall c=%0d got %0b want 0", c, issue_ready); end
            if (wb_valid && wb_rd == 5'd4) n_wb4++;
            if (c == 5) begin
                n_vec++; if (wb_valid !== 1'b1 || wb_data !== fpu_results[95:64]) begin n_bad++; $display("FAIL waw_first_fdiv got v=%0b d=%h want v=1 d=%h", wb_valid, wb_data, fpu_results[95:64]); end
            end
        end
        step(1, 6, 4, 0);
        n_vec++; if (issue_ready !== 1'b1) begin n_bad++; $display("FAIL waw_accept got %0b want 1", issue_ready); end
        if (wb_valid && wb_rd == 5'd4) n_wb4++;
        for (int c = 7; c <= 10; c++) begin
            step(0, 0, 0, 0);
            if (wb_valid && wb_rd == 5'd4) n_wb4++;
            if (c == 8) begin
                n_vec++; if (wb_valid !== 1'b1 || wb_rd !== 5'd4 || wb_data !== fpu_results[223:192]) begin n_bad++; $display("FAIL waw_second_fmul got v=%0b rd=%0d d=%h want v=1 rd=4 d=%h", wb_valid, wb_rd, wb_data, fpu_results[223:192]); end
            end
        end
        n_vec++; if (n_wb4 != 2) begin n_bad++; $display("FAIL waw_wb_count got %0d want 2", n_wb4); end
        drain();
    endtask

    task automatic test_streaming();
        for (int k = 0; k < 10; k++) begin
            step(k < 8, 6, 8 + (k % 8), 0);
            if (k < 8) begin
                n_vec++; if (issue_ready !== 1'b1) begin n_bad++; $display("FAIL stream_ready k=%0d got %0b want 1", k, issue_ready); end
            end
            if (k >= 2) begin
                n_vec++; if (wb_valid !== 1'b1 || wb_rd !== 5'(8 + k - 2)) begin n_bad++; $display("FAIL stream_wb k=%0d got v=%0b rd=%0d want v=1 rd=%0d", k, wb_valid, wb_rd, 8 + k - 2); end
            end
            if (k >= 2 && k <= 7) begin
                n_vec++; if (inflight !== 4'd2) begin n_bad++; $display("FAIL stream_inflight k=%0d got %0d want 2", k, inflight); end
            end
        end
        drain();
    endtask

    task automatic test_flush();
        step(1, 2, 5, 0);
        step(0, 0, 0, 0);
        step(0, 0, 0, 1);
        n_vec++; if (issue_ready !== 1'b0) begin n_bad++; $display("FAIL flush_ready got %0b want 0", issue_ready); end
        step(0, 0, 0, 0);
        n_vec++; if (pending !== 32'd0) begin n_bad++; $display("FAIL flush_pending got %h want 0", pending); end
        n_vec++; if (inflight !== 4'd0) begin n_bad++; $display("FAIL flush_inflight got %0d want 0", inflight); end
        step(0, 0, 0, 0);
        step(0, 0, 0, 0);
        n_vec++; if (wb_valid !== 1'b0) begin n_bad++; $display("FAIL flush_no_wb got %0b want 0", wb_valid); end
        drain();
    endtask

    task automatic test_async_reset();
        int n_wb = 0;
        step(1, 2, 1, 0);
        step(1, 2, 2, 0);
        step(1, 2, 3, 0);
        step(0, 0, 0, 0);
        n_vec++; if (inflight !== 4'd3 || pending !== 32'h0000_000E) begin n_bad++; $display("FAIL arst_pre got infl=%0d pend=%h want 3 0000000e", inflight, pending); end
        #2;
        rstn = 1'b0;
        #1;
        n_vec++; if (wb_valid !== 1'b0) begin n_bad++; $display("FAIL arst_wb_valid got %0b want 0", wb_valid); end
        n_vec++; if (pending !== 32'd0) begin n_bad++; $display("FAIL arst_pending got %h want 0", pending); end
        n_vec++; if (inflight !== 4'd0) begin n_bad++; $display("FAIL arst_inflight got %0d want 0", inflight); end
        evq = {};
        p_v = 0;
        p_fl = 0;
        @(posedge clk);
        #3;
        rstn = 1'b1;
        repeat (8) begin
            step(0, 0, 0, 0);
            if (wb_valid !== 1'b0) n_wb++;
        end
        n_vec++; if (n_wb != 0) begin n_bad++; $display("FAIL arst_late_wb got %0d want 0", n_wb); end
        drain();
    endtask

    task automatic test_random();
        for (int n = 0; n < 1500; n++) begin
            step($urandom_range(0, 9) < 7, $urandom_range(0, 7), $urandom_range(0, 15), $urandom_range(0, 49) == 0);
            n_vec++; if (issue_ready !== e_ready) begin n_bad++; $display("FAIL rnd_ready c=%0d got %0b want %0b", cyc, issue_ready, e_ready); end
            n_vec++; if (wb_valid !== e_valid) begin n_bad++; $display("FAIL rnd_wb_valid c=%0d got %0b want %0b", cyc, wb_valid, e_valid); end
            n_vec++; if (wb_rd !== e_rd) begin n_bad++; $display("FAIL rnd_wb_rd c=%0d got %0d want %0d", cyc, wb_rd, e_rd); end
            n_vec++; if (wb_data !== e_data) begin n_bad++; $display("FAIL rnd_wb_data c=%0d got %h want %h", cyc, wb_data, e_data); end
            n_vec++; if (pending !== e_pend) begin n_bad++; $display("FAIL rnd_pending c=%0d got %h want %h", cyc, pending, e_pend); end
            n_vec++; if (inflight !== 4'(e_infl)) begin n_bad++; $display("FAIL rnd_inflight c=%0d got %0d want %0d", cyc, inflight, e_infl); end
        end
        drain();
    endtask

    initial begin
        test_reset();
        test_idle();
        test_collision();
        test_waw();
        test_streaming();
        test_flush();
        test_async_reset();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
